// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline stage registers
package pipe_pkg;

  // Encoding is {skid_valid, main_valid}; skid-without-main has no code and cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  localparam logic [31:0] NOP_WORD            = 32'h0000_0000;
  localparam int          STALL_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync reset and increment enable
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage with skid slot, flush-to-bubble and stall counter
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] NOP_VAL    = WIDTH'(NOP_WORD),
  parameter int               FLUSH_ZERO = 1,
  parameter int               CNT_W      = STALL_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer;

  assign in_xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (FLUSH_ZERO != 0) begin
        main_d = NOP_VAL;
        skid_d = NOP_VAL;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (in_xfer && out_ready) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid cannot sneak a third beat in.
          if (out_ready) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Pure decode of the state flops, so in_ready never sees out_ready combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      BUSY: out_valid = 1'b1;
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = main_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (out_valid & ~out_ready),
    .cnt_o(stall_cnt)
  );

endmodule
